// File: rtl/uart_tx_sched.sv
// uart_tx_sched: arbitrates 2-byte ALU results and 1-byte register reads onto a single UART TX.
// Define UART_TX_SCHED_RR_ARB_EN for round-robin arbitration; the default build uses fixed ALU-over-RF priority.
module uart_tx_sched #(
  parameter int unsigned ACK_TMO = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_req,
  input  logic [15:0] alu_data,
  output logic        alu_ack,
  input  logic        rf_req,
  input  logic [7:0]  rf_data,
  output logic        rf_ack,
  input  logic        tx_busy,
  output logic [7:0]  tx_p_data,
  output logic        tx_data_valid,
  output logic        sched_busy,
  output logic        tmo_err
);

  // state     | meaning
  // IDLE      | arbitrate pending requests while the UART is free
  // ISSUE     | data_valid strobe for the byte held in tx_p_data
  // WAIT_ACK  | wait for tx_busy to rise, abort after ACK_TMO cycles
  // WAIT_DONE | wait for tx_busy to fall, then send MSB byte or finish
  // DONE      | acknowledge the owner
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE, DONE} state_t;
  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_ALU = 2'd1, OWN_RF = 2'd2} owner_t;

  localparam logic [7:0] TMO_LIMIT = 8'(ACK_TMO);

  state_t     state, state_n;
  owner_t     owner, owner_n;
  logic       idx, idx_n;
  logic [7:0] cnt, cnt_n, cnt_inc;
  logic [7:0] hi_byte, hi_byte_n;
  logic [7:0] p_data_n;
  logic       valid_n, alu_ack_n, rf_ack_n, tmo_n;
  logic       pick_alu;

`ifdef UART_TX_SCHED_RR_ARB_EN
  logic rr_rf, rr_rf_n;  // set: RF wins the next simultaneous request

  assign pick_alu = alu_req && (!rf_req || !rr_rf);

  always_comb begin
    rr_rf_n = rr_rf;
    if (state == DONE) rr_rf_n = (owner == OWN_ALU);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_rf <= 1'b0;
    else     rr_rf <= rr_rf_n;
  end
`else
  assign pick_alu = alu_req;
`endif

  assign cnt_inc    = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
  assign sched_busy = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      owner         <= OWN_NONE;
      idx           <= 1'b0;
      cnt           <= 8'd0;
      hi_byte       <= 8'd0;
      tx_p_data     <= 8'd0;
      tx_data_valid <= 1'b0;
      alu_ack       <= 1'b0;
      rf_ack        <= 1'b0;
      tmo_err       <= 1'b0;
    end else begin
      state         <= state_n;
      owner         <= owner_n;
      idx           <= idx_n;
      cnt           <= cnt_n;
      hi_byte       <= hi_byte_n;
      tx_p_data     <= p_data_n;
      tx_data_valid <= valid_n;
      alu_ack       <= alu_ack_n;
      rf_ack        <= rf_ack_n;
      tmo_err       <= tmo_n;
    end
  end

  always_comb begin
    state_n   = state;
    owner_n   = owner;
    idx_n     = idx;
    cnt_n     = cnt;
    hi_byte_n = hi_byte;
    p_data_n  = tx_p_data;
    valid_n   = 1'b0;
    alu_ack_n = 1'b0;
    rf_ack_n  = 1'b0;
    tmo_n     = 1'b0;
    case (state)
      IDLE: begin
        if (!tx_busy && (alu_req || rf_req)) begin
          state_n = ISSUE;
          idx_n   = 1'b0;
          valid_n = 1'b1;
          if (pick_alu) begin
            owner_n   = OWN_ALU;
            p_data_n  = alu_data[7:0];
            hi_byte_n = alu_data[15:8];
          end else begin
            owner_n  = OWN_RF;
            p_data_n = rf_data;
          end
        end
      end
      ISSUE: begin
        state_n = WAIT_ACK;
        cnt_n   = 8'd0;
      end
      WAIT_ACK: begin
        if (tx_busy) begin
          state_n = WAIT_DONE;
        end else begin
          cnt_n = cnt_inc;
          if (cnt_inc >= TMO_LIMIT) begin
            tmo_n   = 1'b1;
            owner_n = OWN_NONE;
            idx_n   = 1'b0;
            state_n = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) begin
          if (owner == OWN_ALU && !idx) begin
            idx_n    = 1'b1;
            p_data_n = hi_byte;
            valid_n  = 1'b1;
            state_n  = ISSUE;
          end else begin
            alu_ack_n = (owner == OWN_ALU);
            rf_ack_n  = (owner == OWN_RF);
            state_n   = DONE;
          end
        end
      end
      DONE: begin
        owner_n = OWN_NONE;
        idx_n   = 1'b0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter ACK_TMO, default 4, max cycles in WAIT_ACK for tx_busy to rise before abort (range 1..255).
REQ-002 clk  input  1  single clock, rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 alu_req  input  1  level request; 16-bit result pending; alu_data stable while high.
REQ-005 alu_data  input  16  result word, sent LSB byte first, then MSB byte.
REQ-006 alu_ack  output  1  one-cycle pulse; both bytes accepted by the UART TX.
REQ-007 rf_req  input  1  level request; 8-bit register read pending; rf_data stable while high.
REQ-008 rf_data  input  8  register read byte.
REQ-009 rf_ack  output  1  one-cycle pulse; byte accepted by the UART TX.
REQ-010 tx_busy  input  1  UART TX busy flag.
REQ-011 tx_p_data  output  8  byte to UART TX P_DATA; registered.
REQ-012 tx_data_valid  output  1  one-cycle strobe to UART TX data_valid; registered.
REQ-013 sched_busy  output  1  high whenever state != IDLE.
REQ-014 tmo_err  output  1  one-cycle pulse on WAIT_ACK timeout.

Function
REQ-015 States SHALL be IDLE, ISSUE, WAIT_ACK, WAIT_DONE, DONE; 1-bit byte index; 2-bit owner (NONE/ALU/RF); timeout counter, 8 bits.
REQ-016 IDLE: if tx_busy=0 and any req high -> grant per arbitration, latch data, load byte 0 into tx_p_data, byte index=0, go ISSUE; else stay.
REQ-017 IDLE with tx_busy=1 SHALL grant nothing, regardless of requests.
REQ-018 ISSUE: tx_data_valid=1 for exactly this cycle; go WAIT_ACK; counter cleared.
REQ-019 WAIT_ACK: tx_busy=1 -> WAIT_DONE; else counter+1; counter reaching ACK_TMO -> tmo_err pulse, owner NONE, no ack, go IDLE.
REQ-020 Requester whose transaction aborted keeps req high and SHALL be re-arbitrated from byte 0.
REQ-021 WAIT_DONE: wait for tx_busy=0; then if owner=ALU and index=0 -> index=1, tx_p_data=alu_data[15:8] latched copy, go ISSUE; else go DONE.
REQ-022 DONE: pulse owner's ack for one cycle; go IDLE; requests are not sampled in DONE.
REQ-023 Requester SHALL deassert req in the cycle after ack; scheduler samples req again only from the following IDLE cycle.
REQ-024 Latency: req sampled in IDLE at cycle N -> tx_data_valid high at cycle N+1.
REQ-025 Data latched at grant; changes on alu_data/rf_data during transaction SHALL NOT alter transmitted bytes.
REQ-026 tx_p_data SHALL hold its value from grant until the next grant.
REQ-027 Requests arriving while sched_busy=1 SHALL be held pending (level), never lost or preempted.
REQ-028 A req dropped before grant SHALL be ignored; a req dropped after grant SHALL NOT abort the transfer.
REQ-029 Timeout counter SHALL saturate and not wrap.

Reset
REQ-030 rst=1 SHALL asynchronously force IDLE, tx_p_data=0x00, tx_data_valid=0, alu_ack=0, rf_ack=0, tmo_err=0, sched_busy=0, owner NONE, index 0, counter 0, RR pointer to ALU.
REQ-031 Reset mid-transfer SHALL abort without ack; pending requests are re-arbitrated after release.

Configuration
REQ-032 Macro UART_TX_SCHED_RR_ARB_EN defined: round-robin; on simultaneous requests, grant the requester not granted last; pointer updates at DONE only.
REQ-033 Macro undefined: fixed priority, ALU over RF; no pointer logic.

Verification
REQ-034 rf_req=1, rf_data=0xA5, tx_busy modelled 1 for 10 cycles after valid -> one valid strobe with tx_p_data=0xA5, then rf_ack pulse, sched_busy low afterwards.
REQ-035 alu_req=1, alu_data=0x1234 -> valid with 0x34, wait busy cycle, valid with 0x12, single alu_ack after second byte.
REQ-036 alu_req and rf_req rise together, three rounds -> fixed priority: ALU,ALU,ALU only after ALU drops; RR build: ALU,RF,ALU.
REQ-037 tx_busy held 0 after valid, ACK_TMO=4 -> tmo_err pulse 4 cycles into WAIT_ACK, no ack, re-issue of byte 0.
REQ-038 rst asserted during WAIT_DONE of ALU MSB byte -> all outputs zero immediately, no alu_ack; after release, 0x34 re-sent first.
REQ-039 tx_busy=1 in IDLE with rf_req=1 -> no valid until tx_busy=0, then valid next cycle.
